universal_shift_register_n: RTL and testbench

UNIVERSAL_SHIFT_REGISTER_N -- requirements
Module: universal_shift_register_n

---
 rtl/universal_shift_register_n.sv | 116 +++++++++++
 tb/tb_universal_shift_register_n.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register_n.sv
// Universal shift register: shift/rotate/load/retain/clear, optional accumulate (USR_ACCUM_EN).
// Latency: one clock edge from control to q; done and serial outputs are combinational from state.
// Backpressure: none; enable=0 holds all state for the edge.
module universal_shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin,
  input  logic             serial_left_in,
  input  logic             serial_right_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic             cout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_SHR   = 3'b000,
    OP_SHL   = 3'b001,
    OP_HOLD  = 3'b010,
    OP_LOAD  = 3'b011,
    OP_ROR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_ACCUM = 3'b110,
    OP_CLEAR = 3'b111
  } op_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             cout_r, cout_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             is_shift;
  op_t              op;

  assign op = op_t'(control);

`ifndef USR_ACCUM_EN
  // Carry-in only feeds the adder, which is absent in this build.
  logic unused_cin;
  assign unused_cin = cin;
`endif

  always_comb begin
    q_nxt    = q_r;
    cout_nxt = cout_r;
    cnt_nxt  = cnt_r;
    is_shift = 1'b0;
    case (op)
      OP_SHR: begin
        q_nxt    = {serial_left_in, q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_SHL: begin
        q_nxt    = {q_r[WIDTH-2:0], serial_right_in};
        is_shift = 1'b1;
      end
      OP_ROR: begin
        q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_ROL: begin
        q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        is_shift = 1'b1;
      end
      OP_LOAD: begin
        q_nxt    = data_in;
        cout_nxt = 1'b0;
        cnt_nxt  = '0;
      end
      OP_CLEAR: begin
        q_nxt    = '0;
        cout_nxt = 1'b0;
        cnt_nxt  = '0;
      end
`ifdef USR_ACCUM_EN
      OP_ACCUM: begin
        {cout_nxt, q_nxt} = {1'b0, q_r} + {1'b0, data_in} + {{WIDTH{1'b0}}, cin};
        cnt_nxt           = '0;
      end
`endif
      default: ;
    endcase
    // Counter saturates so done stays asserted while shifting continues.
    if (is_shift && (cnt_r != CNT_MAX)) begin
      cnt_nxt = cnt_r + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= '0;
      cout_r <= 1'b0;
      cnt_r  <= '0;
    end else if (enable) begin
      q_r    <= q_nxt;
      cout_r <= cout_nxt;
      cnt_r  <= cnt_nxt;
    end
  end

  assign q                = q_r;
  assign cout             = cout_r;
  assign shift_cnt        = cnt_r;
  assign serial_out_right = q_r[0];
  assign serial_out_left  = q_r[WIDTH-1];
  assign done             = (cnt_r == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Directed bench for universal_shift_register_n at WIDTH=8, default or USR_ACCUM_EN build.
module tb_universal_shift_register_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] C_SHR = 3'b000, C_SHL = 3'b001, C_HOLD = 3'b010, C_LOAD = 3'b011;
  localparam logic [2:0] C_ROR = 3'b100, C_ROL = 3'b101, C_ACC = 3'b110, C_CLR = 3'b111;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [2:0]       control;
  logic [WIDTH-1:0] data_in;
  logic             cin;
  logic             serial_left_in;
  logic             serial_right_in;
  logic [WIDTH-1:0] q;
  logic             serial_out_right;
  logic             serial_out_left;
  logic             cout;
  logic [CNT_W-1:0] shift_cnt;
  logic             done;

  int tests = 0;
  int fails = 0;

  universal_shift_register_n #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .control(control),
    .data_in(data_in), .cin(cin), .serial_left_in(serial_left_in),
    .serial_right_in(serial_right_in), .q(q), .serial_out_right(serial_out_right),
    .serial_out_left(serial_out_left), .cout(cout), .shift_cnt(shift_cnt), .done(done)
  );

  always #5 clock = ~clock;

  // Apply one operation and settle 1ns past the edge that executes it.
  task automatic do_op(input logic [2:0] c, input logic [7:0] d);
    enable  = 1'b1;
    control = c;
    data_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; enable = 1'b1; control = C_LOAD; data_in = 8'hFF;
    cin = 1'b0; serial_left_in = 1'b0; serial_right_in = 1'b0;
    #3 reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    tests++;
    if (q !== 8'h00 || cout !== 1'b0 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: q=%h cout=%b cnt=%0d done=%b, want q=00 cout=0 cnt=0 done=0",
               q, cout, shift_cnt, done);
    end
    #2 reset_n = 1'b1;
    do_op(C_LOAD, 8'h3C);
    tests++;
    if (q !== 8'h3C) begin
      fails++; $display("FAIL reset_release_load: q=%h want 3c", q);
    end
  endtask

  task automatic test_shift_right;
    do_op(C_LOAD, 8'hA5);
    serial_left_in = 1'b1;
    for (int i = 0; i < 4; i++) do_op(C_SHR, 8'h00);
    tests++;
    if (q !== 8'hFA || shift_cnt !== 4'd4 || done !== 1'b0) begin
      fails++;
      $display("FAIL shift_right: q=%h cnt=%0d done=%b, want q=fa cnt=4 done=0", q, shift_cnt, done);
    end
    tests++;
    if (serial_out_right !== 1'b0 || serial_out_left !== 1'b1) begin
      fails++;
      $display("FAIL serial_outs_fa: sor=%b sol=%b, want sor=0 sol=1", serial_out_right, serial_out_left);
    end
    serial_left_in = 1'b0;
  endtask

  task automatic test_shift_left;
    do_op(C_LOAD, 8'h81);
    serial_right_in = 1'b0; do_op(C_SHL, 8'h00);
    serial_right_in = 1'b1; do_op(C_SHL, 8'h00);
    do_op(C_SHL, 8'h00);
    tests++;
    if (q !== 8'h0B || shift_cnt !== 4'd3) begin
      fails++; $display("FAIL shift_left: q=%h cnt=%0d, want q=0b cnt=3", q, shift_cnt);
    end
    tests++;
    if (serial_out_right !== 1'b1 || serial_out_left !== 1'b0) begin
      fails++;
      $display("FAIL serial_outs_0b: sor=%b sol=%b, want sor=1 sol=0", serial_out_right, serial_out_left);
    end
    serial_right_in = 1'b0;
  endtask

  task automatic test_rotate_left;
    serial_right_in = 1'b1;
    do_op(C_LOAD, 8'h81);
    do_op(C_ROL, 8'h00);
    tests++;
    if (q !== 8'h03 || shift_cnt !== 4'd1 || done !== 1'b0) begin
      fails++; $display("FAIL rotl_first: q=%h cnt=%0d done=%b, want q=03 cnt=1 done=0", q, shift_cnt, done);
    end
    for (int i = 0; i < 7; i++) do_op(C_ROL, 8'h00);
    tests++;
    if (q !== 8'h81 || shift_cnt !== 4'd8 || done !== 1'b1) begin
      fails++; $display("FAIL rotl_eight: q=%h cnt=%0d done=%b, want q=81 cnt=8 done=1", q, shift_cnt, done);
    end
    do_op(C_ROL, 8'h00);
    tests++;
    if (q !== 8'h03 || shift_cnt !== 4'd8 || done !== 1'b1) begin
      fails++; $display("FAIL rotl_saturate: q=%h cnt=%0d done=%b, want q=03 cnt=8 done=1", q, shift_cnt, done);
    end
    serial_right_in = 1'b0;
  endtask

  task automatic test_rotate_right;
    serial_left_in = 1'b0;
    do_op(C_LOAD, 8'h01);
    do_op(C_ROR, 8'h00);
    do_op(C_ROR, 8'h00);
    tests++;
    if (q !== 8'h40 || shift_cnt !== 4'd2) begin
      fails++; $display("FAIL rotate_right: q=%h cnt=%0d, want q=40 cnt=2", q, shift_cnt);
    end
  endtask

  task automatic test_retain;
    serial_left_in = 1'b0;
    do_op(C_LOAD, 8'h5A);
    do_op(C_SHR, 8'h00);
    do_op(C_HOLD, 8'hFF);
    tests++;
    if (q !== 8'h2D || shift_cnt !== 4'd1) begin
      fails++; $display("FAIL retain: q=%h cnt=%0d, want q=2d cnt=1", q, shift_cnt);
    end
  endtask

  task automatic test_accumulate;
`ifdef USR_ACCUM_EN
    do_op(C_LOAD, 8'hFF);
    cin = 1'b1; do_op(C_ACC, 8'h05);
    tests++;
    if (q !== 8'h05 || cout !== 1'b1) begin
      fails++; $display("FAIL accum_carry: q=%h cout=%b, want q=05 cout=1", q, cout);
    end
    cin = 1'b0; do_op(C_ACC, 8'h01);
    tests++;
    if (q !== 8'h06 || cout !== 1'b0) begin
      fails++; $display("FAIL accum_nocarry: q=%h cout=%b, want q=06 cout=0", q, cout);
    end
    do_op(C_LOAD, 8'hF0);
    cin = 1'b0; do_op(C_ACC, 8'h20);
    do_op(C_ROL, 8'h00);
    tests++;
    if (q !== 8'h20 || cout !== 1'b1 || shift_cnt !== 4'd1) begin
      fails++; $display("FAIL accum_shift_keeps_cout: q=%h cout=%b cnt=%0d, want q=20 cout=1 cnt=1", q, cout, shift_cnt);
    end
    do_op(C_ACC, 8'h01);
    tests++;
    if (q !== 8'h21 || cout !== 1'b0 || shift_cnt !== 4'd0) begin
      fails++; $display("FAIL accum_cnt_clear: q=%h cout=%b cnt=%0d, want q=21 cout=0 cnt=0", q, cout, shift_cnt);
    end
`else
    do_op(C_LOAD, 8'h3C);
    cin = 1'b1; do_op(C_ACC, 8'hFF);
    tests++;
    if (q !== 8'h3C || cout !== 1'b0) begin
      fails++; $display("FAIL accum_disabled: q=%h cout=%b, want q=3c cout=0", q, cout);
    end
    cin = 1'b0;
`endif
  endtask

  task automatic test_enable_hold;
    do_op(C_LOAD, 8'h55);
    enable = 1'b0; control = C_SHR; serial_left_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (q !== 8'h55 || shift_cnt !== 4'd0) begin
      fails++; $display("FAIL enable_hold: q=%h cnt=%0d, want q=55 cnt=0", q, shift_cnt);
    end
    serial_left_in = 1'b0;
    do_op(C_CLR, 8'hFF);
    tests++;
    if (q !== 8'h00 || cout !== 1'b0 || shift_cnt !== 4'd0) begin
      fails++; $display("FAIL clear: q=%h cout=%b cnt=%0d, want 00/0/0", q, cout, shift_cnt);
    end
  endtask

  task automatic test_async_reset;
    serial_left_in = 1'b1;
    do_op(C_LOAD, 8'hA5);
    repeat (3) do_op(C_SHR, 8'h00);
    tests++;
    if (q !== 8'hF4 || shift_cnt !== 4'd3) begin
      fails++; $display("FAIL pre_reset_shift: q=%h cnt=%0d, want q=f4 cnt=3", q, shift_cnt);
    end
    control = C_SHL; serial_right_in = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (q !== 8'h00 || cout !== 1'b0 || shift_cnt !== 4'd0) begin
      fails++; $display("FAIL async_reset: q=%h cout=%b cnt=%0d, want 00/0/0", q, cout, shift_cnt);
    end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (q !== 8'h01 || shift_cnt !== 4'd1) begin
      fails++; $display("FAIL post_reset_op: q=%h cnt=%0d, want q=01 cnt=1", q, shift_cnt);
    end
    serial_left_in = 1'b0; serial_right_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_shift_left();
    test_rotate_left();
    test_rotate_right();
    test_retain();
    test_accumulate();
    test_enable_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
